instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch/issue sequencer that sits directly upstream of `control_unit`. It holds the program counter and reads 16-bit instruction words from a synchronous instruction memory. Each word is split into the `addr_ins` / `operand1` / `operand2` fields that `control_unit` consumes. It pulses `en` once per instruction, then waits for the execute path to report completion before advancing or jumping.

## Interface
- `PC_W`, default 8: program counter and instruction-memory address width.
- `HALT_OP`, default 8'hFF: opcode that stops the sequencer; it is never issued downstream.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin fetching at the current `pc`; sampled only in IDLE.
- `imem_addr`  out  PC_W  instruction-memory address; always equal to `pc`.
- `imem_data`  in  16  instruction word, valid one cycle after `imem_addr` is sampled; [15:8] opcode, [7:4] operand1, [3:0] operand2.
- `ins_done`  in  1  execute path finished the current instruction; sampled only in EXEC.
- `jump`  in  1  qualifies `ins_done`: next pc comes from `jump_addr`.
- `jump_addr`  in  PC_W  branch target.
- `addr_ins`  out  8  opcode to `control_unit`.
- `operand1`  out  4  first operand to `control_unit`.
- `operand2`  out  4  second operand to `control_unit`.
- `en`  out  1  one-cycle issue strobe to `control_unit`.
- `pc`  out  PC_W  program counter.
- `busy`  out  1  high in FETCH, WAIT, ISSUE and EXEC.
- `halted`  out  1  high in HALT.

## Operation
- **States:** IDLE, FETCH, WAIT, ISSUE, EXEC, HALT. All outputs are registered or decoded from state only.
- **IDLE:** stays in IDLE until `start`=1, then goes to FETCH.
- **FETCH:** `imem_addr`=`pc` is presented. Goes to WAIT unconditionally.
- **WAIT:** `imem_data` is valid.
  - At the end of the cycle, [15:8], [7:4] and [3:0] are latched into `addr_ins`, `operand1` and `operand2`.
  - If [15:8]==`HALT_OP`, go to HALT; otherwise go to ISSUE.
- **ISSUE:** `en`=1 for exactly this cycle. Goes to EXEC.
- **EXEC:** `en`=0. Waits for `ins_done`=1. On `ins_done`:
  - `pc` ← `jump_addr` if `jump`=1, else `pc`+1 modulo 2^PC_W (255+1 → 0 at default width).
  - Next state is FETCH.
- **HALT:** terminal. `start`, `ins_done` and `jump` are ignored. Only `rst` leaves HALT.
- **Field stability:** `addr_ins`, `operand1` and `operand2` keep their value from the WAIT latch until the next WAIT latch. They are stable throughout ISSUE and EXEC. On a halt they hold the `HALT_OP` word's fields.
- **Ignored inputs:** `ins_done` outside EXEC has no effect. `jump` without `ins_done` has no effect.
- **`pc` updates** happen only on `ins_done` in EXEC, or on `rst`.

## Timing
- **Reset values** (the cycle after `rst` is sampled high):
  - state = IDLE.
  - `pc`, `imem_addr`, `addr_ins`, `operand1`, `operand2` = 0.
  - `en`, `busy`, `halted` = 0.
- **Reset priority:** `rst` overrides every other input in every state, including mid-EXEC and HALT. A pending `ins_done` is discarded. No `en` is produced in the cycle after reset.
- **Start latency:** `start` sampled at edge N gives FETCH in N+1, WAIT in N+2, and ISSUE (`en`=1) in N+3.
- **Issue period:** `ins_done` sampled at edge M gives FETCH in M+1 and the next `en` in M+3. The minimum issue period is 4 cycles when `ins_done` arrives in the first EXEC cycle.
- **Memory interface:** exactly one cycle of read latency. `imem_addr` does not change between FETCH and the end of WAIT.
- **Simultaneous inputs:** `start` together with `rst` means reset wins and the block stays in IDLE. `ins_done` together with `jump` in EXEC means the jump is taken.

## Test plan
1. **Reset values:** assert `rst` from an arbitrary state -> next cycle all outputs are 0 and state is IDLE. Hold `start`=0 for 10 cycles -> `en` stays 0 and `pc` stays 0.
2. **Straight-line program:** memory[0]=16'h1234, memory[1]=16'h05A7. Pulse `start`; answer each ISSUE with `ins_done` 2 cycles later.
   - First `en` occurs 3 cycles after `start` with `addr_ins`=8'h12, `operand1`=4'h3, `operand2`=4'h4.
   - Second `en` has `addr_ins`=8'h05, `operand1`=4'hA, `operand2`=4'h7, and `pc`=1.
3. **Jump:** at pc=3, assert `ins_done` with `jump`=1 and `jump_addr`=8'h40 -> `pc`=8'h40 and `imem_addr`=8'h40 in the next FETCH, followed by issue of memory[0x40].
4. **Halt:** memory[2]=16'hFF00 -> after the second instruction completes, `halted`=1 and `busy`=0 with no third `en`. Further `start` or `ins_done` pulses change nothing.
5. **pc wrap-around:** jump to 8'hFF holding a non-halt word; complete it without `jump` -> `pc`=0 and memory[0] is refetched.
6. **Reset mid-operation and stray inputs:**
   - Assert `rst` in the same cycle as `ins_done` in EXEC -> state IDLE, `pc`=0, no `en` issued.
   - Pulse `ins_done` during IDLE and WAIT -> `pc` does not change.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer: holds the pc, reads a one-cycle-latency
// instruction memory, splits each word into opcode/operand fields and strobes
// control_unit once per instruction, advancing or jumping on completion.
module instr_fetch #(
    parameter int unsigned PC_W    = 8,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            ins_done,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_addr,
    output logic [7:0]      addr_ins,
    output logic [3:0]      operand1,
    output logic [3:0]      operand2,
    output logic            en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc_d;
    logic [7:0]      addr_ins_q;
    logic [3:0]      operand1_q;
    logic [3:0]      operand2_q;
    logic            en_q;
    logic            busy_q;
    logic            halted_q;

    // Sequential pc increment; wraps naturally at 2^PC_W.
    always_comb begin
        pc_inc_d = pc_q + PC_W'(1);
    end

    // Sequencer: state, pc, latched fields and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            addr_ins_q <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // imem_addr is already pc; data arrives next cycle.
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    addr_ins_q <= imem_data[15:8];
                    operand1_q <= imem_data[7:4];
                    operand2_q <= imem_data[3:0];
                    if (imem_data[15:8] == HALT_OP) begin
                        state_q  <= ST_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        en_q    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_EXEC;
                    en_q    <= 1'b0;
                end
                ST_EXEC: begin
                    if (ins_done) begin
                        pc_q    <= jump ? jump_addr : pc_inc_d;
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    // Terminal until reset.
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    en_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign addr_ins  = addr_ins_q;
    assign operand1  = operand1_q;
    assign operand2  = operand2_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        ins_done;
    logic        jump;
    logic [7:0]  jump_addr;
    logic [7:0]  addr_ins;
    logic [3:0]  operand1;
    logic [3:0]  operand2;
    logic        en;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) imem_data <= mem[imem_addr];

    instr_fetch #(.PC_W(8), .HALT_OP(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ins_done  (ins_done),
        .jump      (jump),
        .jump_addr (jump_addr),
        .addr_ins  (addr_ins),
        .operand1  (operand1),
        .operand2  (operand2),
        .en        (en),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From an ISSUE cycle: answer with ins_done two cycles later; ends in FETCH.
    task automatic complete(input logic j, input logic [7:0] ja);
        step();
        step();
        ins_done  = 1'b1;
        jump      = j;
        jump_addr = ja;
        step();
        ins_done  = 1'b0;
        jump      = 1'b0;
        jump_addr = 8'h00;
    endtask

    // Bounded wait for the next issue strobe.
    task automatic wait_en(input string tag);
        int n = 0;
        while (en !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(en), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h1234;
        mem[1]     = 16'h05A7;
        mem[2]     = 16'h2222;
        mem[3]     = 16'h3333;
        mem[8'h40] = 16'h4A5B;
        mem[8'hFF] = 16'h7C3D;

        rst = 1'b1; start = 1'b0; ins_done = 1'b0; jump = 1'b0; jump_addr = 8'h00;

        // Reset values
        step();
        step();
        chk("rst_pc",       32'(pc), 0);
        chk("rst_imem",     32'(imem_addr), 0);
        chk("rst_addr_ins", 32'(addr_ins), 0);
        chk("rst_op1",      32'(operand1), 0);
        chk("rst_op2",      32'(operand2), 0);
        chk("rst_en",       32'(en), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_halted",   32'(halted), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_en", 32'(en), 0);
            chk("idle_pc", 32'(pc), 0);
        end

        // Straight-line program: start latency and field split
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_en",   32'(en), 0);
        chk("fetch_imem", 32'(imem_addr), 0);
        step();
        chk("wait_en",    32'(en), 0);
        chk("wait_imem",  32'(imem_addr), 0);
        step();
        chk("i0_en",       32'(en), 1);
        chk("i0_addr_ins", 32'(addr_ins), 'h12);
        chk("i0_op1",      32'(operand1), 'h3);
        chk("i0_op2",      32'(operand2), 'h4);
        chk("i0_pc",       32'(pc), 0);
        step();
        chk("exec_en",     32'(en), 0);
        chk("exec_stable", 32'(addr_ins), 'h12);
        step();
        ins_done = 1'b1;
        step();
        ins_done = 1'b0;
        chk("i1_fetch_pc",   32'(pc), 1);
        chk("i1_fetch_imem", 32'(imem_addr), 1);
        step();
        chk("i1_wait_en", 32'(en), 0);
        step();
        chk("i1_en",       32'(en), 1);
        chk("i1_addr_ins", 32'(addr_ins), 'h05);
        chk("i1_op1",      32'(operand1), 'hA);
        chk("i1_op2",      32'(operand2), 'h7);
        chk("i1_pc",       32'(pc), 1);

        // Advance to pc=3, then jump to 0x40
        complete(1'b0, 8'h00);
        wait_en("i2_en");
        chk("i2_pc",       32'(pc), 2);
        chk("i2_addr_ins", 32'(addr_ins), 'h22);
        complete(1'b0, 8'h00);
        wait_en("i3_en");
        chk("i3_pc", 32'(pc), 3);
        complete(1'b1, 8'h40);
        chk("jmp_pc",   32'(pc), 'h40);
        chk("jmp_imem", 32'(imem_addr), 'h40);
        wait_en("jmp_en");
        chk("jmp_addr_ins", 32'(addr_ins), 'h4A);
        chk("jmp_op1",      32'(operand1), 'h5);
        chk("jmp_op2",      32'(operand2), 'hB);

        // pc wrap-around
        complete(1'b1, 8'hFF);
        chk("ff_pc", 32'(pc), 'hFF);
        wait_en("ff_en");
        chk("ff_addr_ins", 32'(addr_ins), 'h7C);
        complete(1'b0, 8'h00);
        chk("wrap_pc",   32'(pc), 0);
        chk("wrap_imem", 32'(imem_addr), 0);
        wait_en("wrap_en");
        chk("wrap_addr_ins", 32'(addr_ins), 'h12);

        // Reset together with ins_done in EXEC
        step();
        ins_done  = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h77;
        rst       = 1'b1;
        step();
        ins_done = 1'b0; jump = 1'b0; jump_addr = 8'h00; rst = 1'b0;
        chk("mid_rst_pc",       32'(pc), 0);
        chk("mid_rst_en",       32'(en), 0);
        chk("mid_rst_busy",     32'(busy), 0);
        chk("mid_rst_addr_ins", 32'(addr_ins), 0);
        step();
        chk("mid_rst_idle_en",   32'(en), 0);
        chk("mid_rst_idle_busy", 32'(busy), 0);

        // Stray ins_done in IDLE and WAIT
        ins_done = 1'b1; jump = 1'b1; jump_addr = 8'h55;
        step();
        ins_done = 1'b0; jump = 1'b0;
        chk("stray_idle_pc",   32'(pc), 0);
        chk("stray_idle_busy", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ins_done = 1'b1; jump = 1'b1; jump_addr = 8'h55;
        step();
        ins_done = 1'b0; jump = 1'b0; jump_addr = 8'h00;
        chk("stray_wait_en", 32'(en), 1);
        chk("stray_wait_pc", 32'(pc), 0);

        // Halt on HALT_OP at pc=2
        mem[2] = 16'hFF00;
        complete(1'b0, 8'h00);
        wait_en("h1_en");
        chk("h1_pc", 32'(pc), 1);
        complete(1'b0, 8'h00);
        chk("h_fetch_pc", 32'(pc), 2);
        step();
        step();
        chk("halt_halted",   32'(halted), 1);
        chk("halt_busy",     32'(busy), 0);
        chk("halt_en",       32'(en), 0);
        chk("halt_addr_ins", 32'(addr_ins), 'hFF);
        chk("halt_op1",      32'(operand1), 0);
        chk("halt_op2",      32'(operand2), 0);
        start = 1'b1; ins_done = 1'b1; jump = 1'b1; jump_addr = 8'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold_en",     32'(en), 0);
            chk("halt_hold_halted", 32'(halted), 1);
            chk("halt_hold_pc",     32'(pc), 2);
        end
        start = 1'b0; ins_done = 1'b0; jump = 1'b0; jump_addr = 8'h00;

        // Reset leaves HALT
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("unhalt_halted", 32'(halted), 0);
        chk("unhalt_pc",     32'(pc), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
